fetch_decode_stage: RTL and testbench

//  Instruction-fetch / field-split stage of the KGP-RISC datapath. Drives PC into a

---
 rtl/fetch_decode_stage_pkg.sv | 28 ++
 rtl/fd_skid_reg.sv | 39 +++
 rtl/fetch_decode_stage.sv | 135 +++++++++++++
 tb/tb_fetch_decode_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the KGP-RISC fetch/decode stage: instruction field
// positions, FSM state encodings and the PC step helper.
package fetch_decode_stage_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;
  localparam int TGT_HI  = 25;
  localparam int TGT_LO  = 0;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } fd_state_t;

  // Sequential fetch advances one word; wraps naturally at 2^32.
  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fd_skid_reg.sv
// One-entry {pc,instr} holding register used to park a memory return while
// the output register is stalled.
module fd_skid_reg
  import fetch_decode_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [31:0]        load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] instr
);

  logic               valid_reg;
  logic [31:0]        pc_reg;
  logic [INSTR_W-1:0] instr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end
  end

  assign valid = valid_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch into a 1-cycle synchronous IMEM, registered output with
// valid/ready backpressure, 1-entry skid and redirect flush; field slicing.
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [31:0]        id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [5:0]         id_opcode,
  output logic [4:0]         id_rs,
  output logic [4:0]         id_rt,
  output logic [15:0]        id_imm16,
  output logic [25:0]        id_target26
);

  logic [31:0]        fetch_pc_reg;
  logic               inflight_reg;
  logic [31:0]        inflight_pc_reg;
  fd_state_t          state_reg;
  logic               id_valid_reg;
  logic [31:0]        id_pc_reg;
  logic [INSTR_W-1:0] id_instr_reg;

  logic               stalled;
  logic               out_free;
  logic               issue;
  logic               skid_clear;
  logic               skid_load;
  logic               skid_valid;
  logic [31:0]        skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               unused_bits;

  assign stalled   = id_valid_reg & ~id_ready;
  assign out_free  = ~id_valid_reg | id_ready;
  // No read on a redirect cycle: the target is fetched on the following cycle.
  assign issue     = ~rst & ~stalled & ~redirect_valid;
  assign imem_en   = issue;
  assign imem_addr = fetch_pc_reg[IMEM_AW+1:2];
  assign unused_bits = ^redirect_pc[1:0];

  // Skid refills only from a return that the output register cannot take.
  always_comb begin
    skid_clear = 1'b0;
    skid_load  = 1'b0;
    if (redirect_valid) begin
      skid_clear = 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        if (inflight_reg) skid_load  = 1'b1;
        else              skid_clear = 1'b1;
      end
    end else if (inflight_reg) begin
      skid_load = 1'b1;
    end
  end

  fd_skid_reg u_skid (
    .clk        (clk),
    .rst        (rst),
    .clear      (skid_clear),
    .load       (skid_load),
    .load_pc    (inflight_pc_reg),
    .load_instr (imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      state_reg       <= S_BOOT;
      id_valid_reg    <= 1'b0;
      id_pc_reg       <= '0;
      id_instr_reg    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
      inflight_reg <= 1'b0;
      id_valid_reg <= 1'b0;
      state_reg    <= S_RUN;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= fetch_pc_reg;
        fetch_pc_reg    <= pc_step(fetch_pc_reg);
      end

      // Older skid content always drains before a fresh memory return.
      if (out_free) begin
        if (skid_valid) begin
          id_valid_reg <= 1'b1;
          id_pc_reg    <= skid_pc;
          id_instr_reg <= skid_instr;
        end else if (inflight_reg) begin
          id_valid_reg <= 1'b1;
          id_pc_reg    <= inflight_pc_reg;
          id_instr_reg <= imem_rdata;
        end else begin
          id_valid_reg <= 1'b0;
        end
      end

      case (state_reg)
        S_BOOT:  state_reg <= S_RUN;
        S_RUN:   if (stalled && inflight_reg) state_reg <= S_STALL;
        S_STALL: if (id_ready) state_reg <= S_RUN;
        default: state_reg <= S_RUN;
      endcase
    end
  end

  assign id_valid    = id_valid_reg;
  assign id_pc       = id_pc_reg;
  assign id_instr    = id_instr_reg;
  assign id_opcode   = id_instr_reg[OPC_HI:OPC_LO];
  assign id_rs       = id_instr_reg[RS_HI:RS_LO];
  assign id_rt       = id_instr_reg[RT_HI:RT_LO];
  assign id_imm16    = id_instr_reg[IMM_HI:IMM_LO];
  assign id_target26 = id_instr_reg[TGT_HI:TGT_LO];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: a vector table for streaming, stall
// and redirect, plus hand sequences for flush-in-stall, PC wrap and reset.
module tb_fetch_decode_stage;
  import fetch_decode_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        imem_en, imem_en2;
  logic [9:0]  imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        id_valid, id_valid2;
  logic [31:0] id_pc, id_pc2, id_instr, id_instr2;
  logic [5:0]  id_opcode, id_opcode2;
  logic [4:0]  id_rs, id_rs2, id_rt, id_rt2;
  logic [15:0] id_imm16, id_imm162;
  logic [25:0] id_target26, id_target262;

  logic [31:0] rom [0:1023];
  int errors;
  int checks;

  fetch_decode_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_imm16(id_imm16), .id_target26(id_target26)
  );

  fetch_decode_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(10)) dut_wrap (
    .clk(clk), .rst(rst), .imem_en(imem_en2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .id_ready(1'b1), .id_valid(id_valid2),
    .id_pc(id_pc2), .id_instr(id_instr2), .id_opcode(id_opcode2), .id_rs(id_rs2),
    .id_rt(id_rt2), .id_imm16(id_imm162), .id_target26(id_target262)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= rom[imem_addr];
    if (imem_en2) imem_rdata2 <= rom[imem_addr2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle, drive inputs for it, settle before checking.
  task automatic cyc(input logic rdy, input logic redir, input logic [31:0] rpc, input logic r);
    @(posedge clk);
    #1;
    rst = r; id_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_en;
    logic [9:0]  e_addr;
  } vec_t;

  vec_t vecs [19];
  logic [31:0] wrap_pc [3];
  logic [31:0] wrap_instr [3];

  initial begin
    errors = 0; checks = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'(i) * 32'h0101_0101;
    rom[10'h3FE] = 32'hDEAD_0001;
    rom[10'h3FF] = 32'hDEAD_0002;
    imem_rdata = '0; imem_rdata2 = '0;

    vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b1, 10'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b1, 10'd1};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  32'h0,         1'b1, 10'd2};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0101_0101, 1'b1, 10'd3};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h0202_0202, 1'b0, 10'd4};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h0202_0202, 1'b0, 10'd4};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h0202_0202, 1'b0, 10'd4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h0202_0202, 1'b0, 10'd4};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  32'h0202_0202, 1'b1, 10'd4};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  32'h0303_0303, 1'b1, 10'd5};
    vecs[10] = '{1'b1, 1'b1, 32'h40, 1'b1, 32'h10, 32'h0404_0404, 1'b0, 10'd6};
    vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b1, 10'd16};
    vecs[12] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b1, 10'd17};
    vecs[13] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'h1010_1010, 1'b1, 10'd18};
    vecs[14] = '{1'b1, 1'b1, 32'h43, 1'b1, 32'h44, 32'h1111_1111, 1'b0, 10'd19};
    vecs[15] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b1, 10'd16};
    vecs[16] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b1, 10'd17};
    vecs[17] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'h1010_1010, 1'b1, 10'd18};
    vecs[18] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 32'h1111_1111, 1'b1, 10'd19};

    wrap_pc[0] = 32'hFFFF_FFF8; wrap_instr[0] = 32'hDEAD_0001;
    wrap_pc[1] = 32'hFFFF_FFFC; wrap_instr[1] = 32'hDEAD_0002;
    wrap_pc[2] = 32'h0000_0000; wrap_instr[2] = 32'h0000_0000;

    rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk); #1;
    chk("reset_id_valid", {31'b0, id_valid}, 32'd0);
    chk("reset_imem_en",  {31'b0, imem_en},  32'd0);
    chk("reset_id_pc",    id_pc,    32'h0);
    chk("reset_id_instr", id_instr, 32'h0);
    @(posedge clk);

    // Streaming, 4-cycle stall with skid, then two redirects (0x40 and 0x43).
    for (int k = 0; k < 19; k++) begin
      cyc(vecs[k].rdy, vecs[k].redir, vecs[k].rpc, 1'b0);
      $display("cyc %0d: en=%0b addr=%0d valid=%0b pc=%h instr=%h", k, imem_en,
               imem_addr, id_valid, id_pc, id_instr);
      chk($sformatf("v%0d_imem_en", k),   {31'b0, imem_en},  {31'b0, vecs[k].e_en});
      chk($sformatf("v%0d_imem_addr", k), {22'b0, imem_addr}, {22'b0, vecs[k].e_addr});
      chk($sformatf("v%0d_id_valid", k),  {31'b0, id_valid}, {31'b0, vecs[k].e_valid});
      if (vecs[k].e_valid) begin
        chk($sformatf("v%0d_id_pc", k),    id_pc,    vecs[k].e_pc);
        chk($sformatf("v%0d_id_instr", k), id_instr, vecs[k].e_instr);
      end
      if (k >= 2 && k <= 4) begin
        chk($sformatf("wrap%0d_valid", k), {31'b0, id_valid2}, 32'd1);
        chk($sformatf("wrap%0d_pc", k),    id_pc2,    wrap_pc[k-2]);
        chk($sformatf("wrap%0d_instr", k), id_instr2, wrap_instr[k-2]);
      end
    end

    // Redirect while stalled with a full skid: both held entries are dropped.
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    $display("stall: valid=%0b pc=%h en=%0b", id_valid, id_pc, imem_en);
    chk("s4_hold_pc",    id_pc,    32'h48);
    chk("s4_hold_instr", id_instr, 32'h1212_1212);
    chk("s4_hold_en",    {31'b0, imem_en}, 32'd0);
    cyc(1'b0, 1'b1, 32'h80, 1'b0);
    $display("redirect in stall: state=%0d pc=%h", dut.state_reg, id_pc);
    chk("s4_state_stall", {30'b0, dut.state_reg}, {30'b0, S_STALL});
    chk("s4_redir_en",    {31'b0, imem_en}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    $display("after flush: valid=%0b state=%0d addr=%0d", id_valid, dut.state_reg, imem_addr);
    chk("s4_flush_valid", {31'b0, id_valid}, 32'd0);
    chk("s4_state_run",   {30'b0, dut.state_reg}, {30'b0, S_RUN});
    chk("s4_target_addr", {22'b0, imem_addr}, 32'd32);
    chk("s4_target_en",   {31'b0, imem_en}, 32'd1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("s4_bubble2", {31'b0, id_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    $display("target: valid=%0b pc=%h instr=%h", id_valid, id_pc, id_instr);
    chk("s4_t0_valid", {31'b0, id_valid}, 32'd1);
    chk("s4_t0_pc",    id_pc,    32'h80);
    chk("s4_t0_instr", id_instr, 32'h2020_2020);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("s4_t1_pc",    id_pc,    32'h84);
    chk("s4_t1_instr", id_instr, 32'h2121_2121);

    // Reset in the middle of a stall, then refetch from RESET_PC.
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("s6_stall_pc", id_pc, 32'h88);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("s6_rst_en", {31'b0, imem_en}, 32'd0);
    rom[0] = 32'h8C41_FFFC;
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    $display("mid-stall reset: valid=%0b en=%0b", id_valid, imem_en);
    chk("s6_rst_valid",  {31'b0, id_valid}, 32'd0);
    chk("s6_rst_en2",    {31'b0, imem_en},  32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("s6_rel_valid", {31'b0, id_valid}, 32'd0);
    chk("s6_rel_en",    {31'b0, imem_en},  32'd1);
    chk("s6_rel_addr",  {22'b0, imem_addr}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("s6_lat_valid", {31'b0, id_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    $display("refetch: pc=%h instr=%h opc=%h rs=%0d rt=%0d imm=%h tgt=%h", id_pc, id_instr,
             id_opcode, id_rs, id_rt, id_imm16, id_target26);
    chk("s6_valid",    {31'b0, id_valid},    32'd1);
    chk("s6_pc",       id_pc,                32'h0);
    chk("s6_instr",    id_instr,             32'h8C41_FFFC);
    chk("s6_opcode",   {26'b0, id_opcode},   32'h23);
    chk("s6_rs",       {27'b0, id_rs},       32'd2);
    chk("s6_rt",       {27'b0, id_rt},       32'd1);
    chk("s6_imm16",    {16'b0, id_imm16},    32'hFFFC);
    chk("s6_target26", {6'b0, id_target26},  32'h0041_FFFC);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("s6_next_pc",    id_pc,    32'h4);
    chk("s6_next_instr", id_instr, 32'h0101_0101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
